// File: rtl/h264_core_transform4x4.sv
// Forward 4x4 H.264 integer core transform: row-wise horizontal butterfly into ping-pong
// banks, then a column-wise vertical butterfly that emits one coefficient per transfer.
module h264_core_transform4x4 #(
  parameter int IW = 9,
  parameter int OW = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            STROBEI,
  input  logic [4*IW-1:0] DATAI,
  output logic            READYI,
  output logic            STROBEO,
  output logic [OW-1:0]   DATAO,
  output logic [3:0]      IDXO,
  output logic            LASTO,
  input  logic            READYO
);
  localparam int HW = IW + 3;
  localparam int YW = IW + 6;

  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, nstate;

  logic signed [HW-1:0] hbuf [2][4][4];
  logic [1:0] full;
  logic       wbank, rbank;
  logic [1:0] wrow;
  logic       accept;

  logic                 pvalid, pbank;
  logic [1:0]           prow;
  logic signed [HW-1:0] ph [4];

  logic signed [HW-1:0] xe [4];
  logic signed [HW-1:0] hrow [4];
  logic signed [HW-1:0] hs03, hd03, hs12, hd12;

  logic                 xfer, lastxfer, load, nstrobe, ldbank;
  logic [3:0]           ldidx;
  logic signed [YW-1:0] col [4];
  logic signed [YW-1:0] vs03, vd03, vs12, vd12, ysel;

  assign READYI   = ~full[wbank];
  assign accept   = STROBEI & READYI;
  assign xfer     = STROBEO & READYO;
  assign lastxfer = (state == DRAIN) & xfer & LASTO;

  always_comb begin
    for (int j = 0; j < 4; j++)
      xe[j] = {{3{DATAI[j*IW+IW-1]}}, DATAI[j*IW +: IW]};
    hs03 = xe[0] + xe[3];
    hd03 = xe[0] - xe[3];
    hs12 = xe[1] + xe[2];
    hd12 = xe[1] - xe[2];
    hrow[0] = hs03 + hs12;
    hrow[1] = (hd03 <<< 1) + hd12;
    hrow[2] = hs03 - hs12;
    hrow[3] = hd03 - (hd12 <<< 1);
  end

  // One register stage between row acceptance and the bank write; full is raised as row 3 lands.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrow   <= 2'd0;
      wbank  <= 1'b0;
      pvalid <= 1'b0;
      pbank  <= 1'b0;
      prow   <= 2'd0;
      for (int v = 0; v < 4; v++) ph[v] <= '0;
    end else begin
      pvalid <= accept;
      if (accept) begin
        pbank <= wbank;
        prow  <= wrow;
        for (int v = 0; v < 4; v++) ph[v] <= hrow[v];
        wrow <= wrow + 2'd1;
        if (wrow == 2'd3) wbank <= ~wbank;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (pvalid)
      for (int v = 0; v < 4; v++) hbuf[pbank][prow][v] <= ph[v];
  end

  always_comb begin
    nstate  = state;
    nstrobe = STROBEO;
    load    = 1'b0;
    ldbank  = rbank;
    ldidx   = 4'd0;
    case (state)
      IDLE: begin
        if (full[rbank]) begin
          nstate  = DRAIN;
          nstrobe = 1'b1;
          load    = 1'b1;
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (LASTO) begin
            if (full[~rbank]) begin
              load   = 1'b1;
              ldbank = ~rbank;
            end else begin
              nstate  = IDLE;
              nstrobe = 1'b0;
            end
          end else begin
            load  = 1'b1;
            ldidx = IDXO + 4'd1;
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Vertical butterfly over column v of the selected bank, row u picked by the index.
  always_comb begin
    for (int i = 0; i < 4; i++)
      col[i] = {{3{hbuf[ldbank][i][ldidx[1:0]][HW-1]}}, hbuf[ldbank][i][ldidx[1:0]]};
    vs03 = col[0] + col[3];
    vd03 = col[0] - col[3];
    vs12 = col[1] + col[2];
    vd12 = col[1] - col[2];
    case (ldidx[3:2])
      2'd0:    ysel = vs03 + vs12;
      2'd1:    ysel = (vd03 <<< 1) + vd12;
      2'd2:    ysel = vs03 - vs12;
      default: ysel = vd03 - (vd12 <<< 1);
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      STROBEO <= 1'b0;
      DATAO   <= '0;
      IDXO    <= 4'd0;
      LASTO   <= 1'b0;
      rbank   <= 1'b0;
      full    <= 2'b00;
    end else begin
      state   <= nstate;
      STROBEO <= nstrobe;
      if (load) begin
        DATAO <= OW'(ysel);
        IDXO  <= ldidx;
        LASTO <= (ldidx == 4'd15);
      end
      // The filling bank is never the draining bank, so set and clear cannot collide.
      if (pvalid && prow == 2'd3) full[pbank] <= 1'b1;
      if (lastxfer) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end
    end
  end

endmodule

// File: tb/tb_h264_core_transform4x4.sv
// Bench for h264_core_transform4x4: matrix-product model Y = Cf*X*Cf^T, a per-cycle compare
// process, and directed blocks with literal expectations.
module tb_h264_core_transform4x4;
  localparam int IW = 9;
  localparam int OW = 16;
  typedef int blk_t [4][4];

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            STROBEI = 1'b0;
  logic [4*IW-1:0] DATAI = '0;
  logic            READYO = 1'b1;
  logic            READYI, STROBEO, LASTO;
  logic [OW-1:0]   DATAO;
  logic [3:0]      IDXO;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int expData[$];
  int expIdx[$];
  int xferEdges[$];
  int lastEdges[$];
  int capt[16];
  int strobeRiseEdge = -1;
  bit prevStrobe = 0;
  bit prevStall = 0;
  int prevData = 0;
  int prevIdx = 0;
  int sdata;
  int cf[4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

  h264_core_transform4x4 #(.IW(IW), .OW(OW)) dut (
    .CLK(CLK), .RST_N(RST_N), .STROBEI(STROBEI), .DATAI(DATAI), .READYI(READYI),
    .STROBEO(STROBEO), .DATAO(DATAO), .IDXO(IDXO), .LASTO(LASTO), .READYO(READYO)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelBlock(input blk_t x);
    for (int u = 0; u < 4; u++)
      for (int v = 0; v < 4; v++) begin
        int y = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            y += cf[u][i] * x[i][j] * cf[v][j];
        expData.push_back(y);
        expIdx.push_back(4 * u + v);
      end
  endtask

  // Compare process: every cycle with STROBEO high is checked against the model queue.
  always @(negedge CLK) begin
    if (!RST_N) begin
      prevStrobe = 0;
      prevStall  = 0;
    end else begin
      sdata = int'($signed(DATAO));
      if (STROBEO && !prevStrobe) strobeRiseEdge = cycle;
      if (prevStall) begin
        checkOutput("hold_data", sdata, prevData);
        checkOutput("hold_idx", int'(IDXO), prevIdx);
      end
      if (STROBEO) begin
        if (expData.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_strobe: got idx %0d data %0d, expected no output", IDXO, sdata);
        end else begin
          checkOutput("coef_data", sdata, expData[0]);
          checkOutput("coef_idx", int'(IDXO), expIdx[0]);
          checkOutput("coef_last", int'(LASTO), int'(expIdx[0] == 15));
          if (READYO) begin
            capt[IDXO] = sdata;
            xferEdges.push_back(cycle + 1);
            if (LASTO) lastEdges.push_back(cycle + 1);
            void'(expData.pop_front());
            void'(expIdx.pop_front());
          end
        end
      end
      prevStrobe = STROBEO;
      prevStall  = STROBEO && !READYO;
      prevData   = sdata;
      prevIdx    = int'(IDXO);
    end
  end

  task automatic sendRow(input logic [4*IW-1:0] d, output int accEdge);
    bit ok = 0;
    accEdge = -1;
    STROBEI = 1'b1;
    DATAI   = d;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge CLK);
      if (READYI) begin
        @(posedge CLK);
        #1;
        accEdge = cycle;
        ok = 1;
      end
    end
    STROBEI = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL row_accept: READYI stayed 0, expected 1 within 300 cycles");
    end
  endtask

  function automatic logic [4*IW-1:0] packRow(input blk_t x, input int r);
    logic [4*IW-1:0] d;
    for (int j = 0; j < 4; j++) d[j*IW +: IW] = IW'(x[r][j]);
    return d;
  endfunction

  task automatic applyStimulus(input blk_t x, output int firstEdge, output int lastEdge);
    int e;
    firstEdge = -1;
    lastEdge  = -1;
    for (int r = 0; r < 4; r++) begin
      sendRow(packRow(x, r), e);
      if (r == 0) firstEdge = e;
      if (r == 3) begin
        lastEdge = e;
        modelBlock(x);
      end
    end
  endtask

  task automatic waitDrain(input string name);
    for (int t = 0; t < 600 && expData.size() > 0; t++) @(negedge CLK);
    if (expData.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_drain: %0d coefficients outstanding, expected 0", name, expData.size());
      expData.delete();
      expIdx.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic fillBlock(output blk_t x, input int seed);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        x[i][j] = ((i * 4 + j) * 37 + seed * 91) % 511 - 255;
  endtask

  initial begin
    blk_t b, bb[3];
    int f, e, f3, e3, dummy;
    int imp[16] = '{1, 2, 1, 1, 2, 4, 2, 2, 1, 2, 1, 1, 1, 2, 1, 1};
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_strobeo", int'(STROBEO), 0);
    checkOutput("reset_datao", int'(DATAO), 0);
    checkOutput("reset_idxo", int'(IDXO), 0);
    checkOutput("reset_lasto", int'(LASTO), 0);
    checkOutput("reset_readyi", int'(READYI), 1);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] all-ones block");
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) b[i][j] = 1;
    applyStimulus(b, f, e);
    waitDrain("t1");
    checkOutput("t1_idx0", capt[0], 16);
    for (int k = 1; k < 16; k++) checkOutput("t1_idx_zero", capt[k], 0);
    checkOutput("t1_latency", strobeRiseEdge - e, 2);

    $display("[TB] impulse block");
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) b[i][j] = 0;
    b[0][0] = 1;
    applyStimulus(b, f, e);
    waitDrain("t2");
    for (int k = 0; k < 16; k++) checkOutput("t2_impulse", capt[k], imp[k]);

    $display("[TB] extreme blocks");
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) b[i][j] = -255;
    applyStimulus(b, f, e);
    waitDrain("t3n");
    checkOutput("t3_neg_idx0", capt[0], -4080);
    checkOutput("t3_neg_idx15", capt[15], 0);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) b[i][j] = 255;
    applyStimulus(b, f, e);
    waitDrain("t3p");
    checkOutput("t3_pos_idx0", capt[0], 4080);

    $display("[TB] three blocks back-to-back");
    for (int k = 0; k < 3; k++) fillBlock(bb[k], k + 1);
    xferEdges.delete();
    lastEdges.delete();
    applyStimulus(bb[0], f, e);
    applyStimulus(bb[1], f, e);
    @(negedge CLK);
    checkOutput("t4_readyi_low", int'(READYI), 0);
    applyStimulus(bb[2], f3, e3);
    if (lastEdges.size() > 0) checkOutput("t4_readyi_rise", f3, lastEdges[0] + 1);
    else checkOutput("t4_block1_last_seen", lastEdges.size(), 1);
    waitDrain("t4");
    checkOutput("t4_count", xferEdges.size(), 48);
    if (xferEdges.size() == 48) checkOutput("t4_contiguous", xferEdges[47] - xferEdges[0], 47);

    $display("[TB] backpressure during drain");
    fillBlock(b, 7);
    applyStimulus(b, f, e);
    for (int k = 0; k < 400 && expData.size() > 0; k++) begin
      READYO = pat[k % 4];
      @(posedge CLK);
      #1;
    end
    READYO = 1'b1;
    waitDrain("t5");

    $display("[TB] reset after two rows");
    fillBlock(b, 11);
    sendRow(packRow(b, 0), dummy);
    sendRow(packRow(b, 1), dummy);
    #1;
    RST_N = 1'b0;
    #1;
    checkOutput("t6a_readyi", int'(READYI), 1);
    checkOutput("t6a_strobeo", int'(STROBEO), 0);
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    fillBlock(b, 13);
    applyStimulus(b, f, e);
    waitDrain("t6a");

    $display("[TB] reset during drain");
    fillBlock(b, 17);
    applyStimulus(b, f, e);
    for (int t = 0; t < 100 && expData.size() > 10; t++) @(negedge CLK);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("t6b_strobeo", int'(STROBEO), 0);
    checkOutput("t6b_datao", int'(DATAO), 0);
    checkOutput("t6b_idxo", int'(IDXO), 0);
    checkOutput("t6b_lasto", int'(LASTO), 0);
    checkOutput("t6b_readyi", int'(READYI), 1);
    expData.delete();
    expIdx.delete();
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    fillBlock(b, 19);
    applyStimulus(b, f, e);
    waitDrain("t6b");
    repeat (5) @(posedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
